// File: rtl/baseline_order_gen.sv
// ---------------------------------------------------------------------------
// baseline_order_gen
//   Labels each valid word of the X-engine output stream with its antenna
//   pair (ant_a, ant_b) and a buffer-select flag. The tap index is the fastest
//   running index, and the row index follows it. One window holds
//   N_ANTS * N_TAPS valid words.
//
//   Optional feature macro: BL_ORDER_LAST_EN
//     When it is defined, the output port 'last' is added. It flags the final
//     word of a window. When it is undefined, the port and its logic are absent.
// ---------------------------------------------------------------------------
module baseline_order_gen #(
  parameter  int N_ANTS   = 32,
  localparam int ANT_BITS = $clog2(N_ANTS),
  localparam int N_TAPS   = N_ANTS / 2 + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sync,
  input  logic                en,
  output logic [ANT_BITS-1:0] ant_a,
  output logic [ANT_BITS-1:0] ant_b,
  output logic                buf_sel
`ifdef BL_ORDER_LAST_EN
  ,
  output logic                last
`endif
);

  // The tap counter never exceeds N_ANTS/2, so it fits in the antenna index
  // width. Sharing the width keeps ant_b a plain modular subtraction.
  localparam logic [ANT_BITS-1:0] ROW_MAX  = ANT_BITS'(N_ANTS - 1);
  localparam logic [ANT_BITS-1:0] TAP_MAX  = ANT_BITS'(N_TAPS - 1);
  localparam logic [ANT_BITS-1:0] IDX_ZERO = {ANT_BITS{1'b0}};
  localparam logic [ANT_BITS-1:0] IDX_ONE  = ANT_BITS'(1);

  logic [ANT_BITS-1:0] row_r;
  logic [ANT_BITS-1:0] tap_r;
  logic [ANT_BITS-1:0] row_nxt_s;
  logic [ANT_BITS-1:0] tap_nxt_s;
  logic                tap_end_s;
  logic                row_end_s;

  // End-of-row and end-of-window detection from the current state.
  always_comb begin
    tap_end_s = 1'b0;
    row_end_s = 1'b0;
    if (tap_r == TAP_MAX) begin
      tap_end_s = 1'b1;
    end else begin
      tap_end_s = 1'b0;
    end
    if (row_r == ROW_MAX) begin
      row_end_s = 1'b1;
    end else begin
      row_end_s = 1'b0;
    end
  end

  // Next-state logic. Sync restarts the window and overrides en.
  // en advances the tap, and the row steps when the tap wraps.
  always_comb begin
    row_nxt_s = row_r;
    tap_nxt_s = tap_r;
    if (sync) begin
      row_nxt_s = IDX_ZERO;
      tap_nxt_s = IDX_ZERO;
    end else if (en) begin
      if (tap_end_s) begin
        tap_nxt_s = IDX_ZERO;
        if (row_end_s) begin
          row_nxt_s = IDX_ZERO;
        end else begin
          row_nxt_s = row_r + IDX_ONE;
        end
      end else begin
        tap_nxt_s = tap_r + IDX_ONE;
        row_nxt_s = row_r;
      end
    end else begin
      row_nxt_s = row_r;
      tap_nxt_s = tap_r;
    end
  end

  // Row/tap state register. An asynchronous reset returns it to the window start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= IDX_ZERO;
      tap_r <= IDX_ZERO;
    end else begin
      row_r <= row_nxt_s;
      tap_r <= tap_nxt_s;
    end
  end

  // Labels are decoded from the registered state only, so they stay stable
  // while en is low. They do not depend on sync or en.
  always_comb begin
    ant_a   = row_r;
    ant_b   = row_r - tap_r;
    buf_sel = 1'b0;
    if (tap_r > row_r) begin
      buf_sel = 1'b1;
    end else begin
      buf_sel = 1'b0;
    end
  end

`ifdef BL_ORDER_LAST_EN
  // Flags the final word of a window: the last row and the last tap.
  always_comb begin
    last = 1'b0;
    if (row_end_s && tap_end_s) begin
      last = 1'b1;
    end else begin
      last = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_baseline_order_gen.sv
// ---------------------------------------------------------------------------
// tb_baseline_order_gen
//   Scoreboard bench for baseline_order_gen with N_ANTS=32. The expected
//   labels come from a simple integer model of the row/tap sequence. They are
//   pushed when stimulus is driven and popped after the clock edge. Fixed
//   reference labels at chosen word indices are checked as well.
// ---------------------------------------------------------------------------
module tb_baseline_order_gen;

  localparam int N_ANTS = 32;
  localparam int N_TAPS = 17;

  typedef struct {
    int a;
    int b;
    int bs;
    int lst;
  } label_t;

  logic       clk;
  logic       rst_n;
  logic       sync;
  logic       en;
  logic [4:0] ant_a;
  logic [4:0] ant_b;
  logic       buf_sel;
`ifdef BL_ORDER_LAST_EN
  logic       last;
`endif

  int total;
  int bad;
  int mr;
  int mt;
  int k;
  label_t sb_q[$];

  // Reference labels: word index, ant_a, ant_b, buf_sel, last.
  int ref_k  [9] = '{0, 1, 16, 17, 18, 19, 20, 543, 544};
  int ref_a  [9] = '{0, 0, 0, 1, 1, 1, 1, 31, 0};
  int ref_b  [9] = '{0, 31, 16, 1, 0, 31, 30, 15, 0};
  int ref_bs [9] = '{0, 1, 1, 0, 0, 1, 1, 0, 0};
  int ref_ls [9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

  baseline_order_gen #(.N_ANTS(N_ANTS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync    (sync),
    .en      (en),
    .ant_a   (ant_a),
    .ant_b   (ant_b),
    .buf_sel (buf_sel)
`ifdef BL_ORDER_LAST_EN
    ,
    .last    (last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", tag, obs, exp, k, $time);
    end
  endtask

  function automatic label_t model_label(input int r, input int t);
    label_t l;
    l.a  = r;
    l.b  = (r - t + N_ANTS) % N_ANTS;
    l.bs = (t > r) ? 1 : 0;
`ifdef BL_ORDER_LAST_EN
    l.lst = (r == N_ANTS - 1 && t == N_TAPS - 1) ? 1 : 0;
`else
    l.lst = 0;
`endif
    return l;
  endfunction

  task automatic check_outputs(input string tag, input label_t l);
    check_val({tag, "_ant_a"}, 32'(ant_a), l.a);
    check_val({tag, "_ant_b"}, 32'(ant_b), l.b);
    check_val({tag, "_buf_sel"}, 32'(buf_sel), l.bs);
`ifdef BL_ORDER_LAST_EN
    check_val({tag, "_last"}, 32'(last), l.lst);
`endif
  endtask

  task automatic check_reference();
    label_t l;
    for (int i = 0; i < 9; i++) begin
      if (ref_k[i] == k) begin
        l.a  = ref_a[i];
        l.b  = ref_b[i];
        l.bs = ref_bs[i];
        l.lst = ref_ls[i];
        check_outputs($sformatf("ref_k%0d", k), l);
      end
    end
  endtask

  // Drive one cycle of stimulus. The model is updated and the expected label
  // is queued. After the edge, the queued label is compared with the DUT outputs.
  task automatic step(input logic s, input logic e, input bit use_ref);
    label_t exp_l;
    label_t got_l;
    sync = s;
    en   = e;
    if (s) begin
      mr = 0;
      mt = 0;
      k  = 0;
    end else if (e) begin
      mt++;
      k++;
      if (mt == N_TAPS) begin
        mt = 0;
        mr++;
        if (mr == N_ANTS) mr = 0;
      end
    end
    exp_l = model_label(mr, mt);
    sb_q.push_back(exp_l);
    @(posedge clk);
    #1;
    sync = 1'b0;
    en   = 1'b0;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      got_l = sb_q.pop_front();
      check_outputs("sb", got_l);
    end
    if (use_ref) check_reference();
  endtask

  initial begin
    label_t zero_l;
    zero_l = model_label(0, 0);
    total = 0;
    bad   = 0;
    mr = 0;
    mt = 0;
    k  = 0;
    rst_n = 1'b0;
    sync  = 1'b0;
    en    = 1'b0;

    // Reset values before any clock edge.
    #2;
    check_outputs("reset", zero_l);
    en = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("reset_hold", zero_l);
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sync, then 20 words, a 5-cycle en gap, and a resume up to k=100.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b1);
    check_val("k_before_sync", 32'(k), 32'd100);

    // Sync with en=1 at k=100. Sync wins, then a full window plus wrap.
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 560; i++) step(1'b0, 1'b1, 1'b1);

    // Restart and run to k=300, then apply an async reset for one cycle.
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", zero_l);
    mr = 0;
    mt = 0;
    k  = 0;
    en = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("async_rst_hold", zero_l);
    en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);

    // Random en with occasional sync. Only the scoreboard checks apply here.
    for (int i = 0; i < 1200; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'b0);
    end

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
